// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the register-file writeback scheduler.
//   XLEN / REG_AW     : default data width and register address width
//   NUM_REGS          : number of architectural registers (2**REG_AW)
//   REQ_ALU / REQ_LSU : requester indices used by the arbiter pointer
//   wb_req_t          : one writeback entry {rd, data} at default widths
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 1 << REG_AW;

   localparam int unsigned REQ_ALU  = 0;
   localparam int unsigned REQ_LSU  = 1;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
//   Busy bit per architectural register. A set marks a register as having an
//   outstanding writer; a clear retires it. Register 0 is never pending.
//   Ports:
//     I_clk, I_rst_n        clock, asynchronous active-low reset
//     I_set_en, I_set_rd    mark rd pending (issue)
//     I_clr_en, I_clr_rd    clear rd (committed write)
//     I_rs1, I_rs2          lookup addresses
//     O_rs1_pend/O_rs2_pend combinational pending status of I_rs1 / I_rs2
// -----------------------------------------------------------------------------
module wb_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned REG_AW = regfile_pkg::REG_AW
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_set_en,
   input  logic [REG_AW-1:0] I_set_rd,
   input  logic              I_clr_en,
   input  logic [REG_AW-1:0] I_clr_rd,
   input  logic [REG_AW-1:0] I_rs1,
   input  logic [REG_AW-1:0] I_rs2,
   output logic              O_rs1_pend,
   output logic              O_rs2_pend
);

   localparam int unsigned NREGS = 1 << REG_AW;

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;

   // Clear is applied before set so a same-cycle issue to the register being
   // retired leaves it pending for the newer instruction.
   always_comb begin
      pending_d = pending_q;
      if (I_clr_en) pending_d[I_clr_rd] = 1'b0;
      if (I_set_en) pending_d[I_set_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) pending_q <= '0;
      else          pending_q <= pending_d;
   end

   assign O_rs1_pend = pending_q[I_rs1];
   assign O_rs2_pend = pending_q[I_rs2];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//   Shares the single register-file write port between the ALU (A) and the
//   load/store unit (L). Each requester owns a one-entry holding buffer; one
//   buffer is granted per cycle and its entry is written through registered
//   O_rf_we / O_rf_rd / O_rf_data. A busy scoreboard tracks issued-but-not-
//   written destinations and raises O_hazard for pending rs1/rs2.
//   Ports:
//     I_clk, I_rst_n                     clock, asynchronous active-low reset
//     I_alu_valid/O_alu_ready/I_alu_rd/I_alu_data   ALU writeback handshake
//     I_lsu_valid/O_lsu_ready/I_lsu_rd/I_lsu_data   load writeback handshake
//     I_issue_valid, I_issue_rd          mark destination pending on issue
//     I_rs1, I_rs2, O_hazard             combinational source-busy check
//     O_rf_we, O_rf_rd, O_rf_data        registered register-file write port
//   Configuration:
//     REGFILE_WB_RR_EN defined   : round-robin grant between full buffers,
//                                  pointer moves only on a grant, reset
//                                  pointer favours L.
//     REGFILE_WB_RR_EN undefined : fixed priority L > A; A can starve under
//                                  continuous L traffic.
// -----------------------------------------------------------------------------
module regfile_wb_scheduler
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN   = regfile_pkg::XLEN,
   parameter int unsigned REG_AW = regfile_pkg::REG_AW
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_alu_valid,
   output logic              O_alu_ready,
   input  logic [REG_AW-1:0] I_alu_rd,
   input  logic [XLEN-1:0]   I_alu_data,
   input  logic              I_lsu_valid,
   output logic              O_lsu_ready,
   input  logic [REG_AW-1:0] I_lsu_rd,
   input  logic [XLEN-1:0]   I_lsu_data,
   input  logic              I_issue_valid,
   input  logic [REG_AW-1:0] I_issue_rd,
   input  logic [REG_AW-1:0] I_rs1,
   input  logic [REG_AW-1:0] I_rs2,
   output logic              O_hazard,
   output logic              O_rf_we,
   output logic [REG_AW-1:0] O_rf_rd,
   output logic [XLEN-1:0]   O_rf_data
);

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } req_t;

   // Holding buffers
   logic alu_full_q, alu_full_d;
   logic lsu_full_q, lsu_full_d;
   req_t alu_buf_q,  alu_buf_d;
   req_t lsu_buf_q,  lsu_buf_d;

   // Output register
   logic              rf_we_q,   rf_we_d;
   logic [REG_AW-1:0] rf_rd_q,   rf_rd_d;
   logic [XLEN-1:0]   rf_data_q, rf_data_d;

   logic gnt_alu, gnt_lsu;
   logic alu_acc, lsu_acc;
   logic rs1_pend, rs2_pend;

`ifdef REGFILE_WB_RR_EN
   // Last granted requester; reset to ALU so the first contended grant goes to L.
   logic last_q, last_d;
`endif

   // ---------------------------------------------------------------- arbiter
   always_comb begin
      gnt_alu = 1'b0;
      gnt_lsu = 1'b0;
      if (alu_full_q && lsu_full_q) begin
`ifdef REGFILE_WB_RR_EN
         if (last_q == 1'(REQ_LSU)) gnt_alu = 1'b1;
         else                       gnt_lsu = 1'b1;
`else
         gnt_lsu = 1'b1;
`endif
      end else begin
         gnt_alu = alu_full_q;
         gnt_lsu = lsu_full_q;
      end
   end

`ifdef REGFILE_WB_RR_EN
   always_comb begin
      last_d = last_q;
      if (gnt_lsu)      last_d = 1'(REQ_LSU);
      else if (gnt_alu) last_d = 1'(REQ_ALU);
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) last_q <= 1'(REQ_ALU);
      else          last_q <= last_d;
   end
`endif

   // ---------------------------------------------------------------- handshake
   assign O_alu_ready = !alu_full_q || gnt_alu;
   assign O_lsu_ready = !lsu_full_q || gnt_lsu;
   assign alu_acc     = I_alu_valid && O_alu_ready;
   assign lsu_acc     = I_lsu_valid && O_lsu_ready;

   // Writes to x0 are accepted but never enter a buffer, so they cost no
   // grant slot and never reach the write port or the scoreboard.
   always_comb begin
      alu_full_d = alu_full_q;
      alu_buf_d  = alu_buf_q;
      if (gnt_alu) alu_full_d = 1'b0;
      if (alu_acc && (I_alu_rd != '0)) begin
         alu_full_d = 1'b1;
         alu_buf_d  = '{rd: I_alu_rd, data: I_alu_data};
      end
   end

   always_comb begin
      lsu_full_d = lsu_full_q;
      lsu_buf_d  = lsu_buf_q;
      if (gnt_lsu) lsu_full_d = 1'b0;
      if (lsu_acc && (I_lsu_rd != '0)) begin
         lsu_full_d = 1'b1;
         lsu_buf_d  = '{rd: I_lsu_rd, data: I_lsu_data};
      end
   end

   // ---------------------------------------------------------------- write port
   always_comb begin
      rf_we_d   = gnt_alu || gnt_lsu;
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      if (gnt_lsu) begin
         rf_rd_d   = lsu_buf_q.rd;
         rf_data_d = lsu_buf_q.data;
      end else if (gnt_alu) begin
         rf_rd_d   = alu_buf_q.rd;
         rf_data_d = alu_buf_q.data;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         alu_full_q <= 1'b0;
         lsu_full_q <= 1'b0;
         alu_buf_q  <= '0;
         lsu_buf_q  <= '0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_data_q  <= '0;
      end else begin
         alu_full_q <= alu_full_d;
         lsu_full_q <= lsu_full_d;
         alu_buf_q  <= alu_buf_d;
         lsu_buf_q  <= lsu_buf_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_data_q  <= rf_data_d;
      end
   end

   assign O_rf_we   = rf_we_q;
   assign O_rf_rd   = rf_rd_q;
   assign O_rf_data = rf_data_q;

   // ---------------------------------------------------------------- scoreboard
   // Retire on the cycle the write is visible on the port.
   wb_scoreboard #(
      .REG_AW (REG_AW)
   ) u_scoreboard (
      .I_clk      (I_clk),
      .I_rst_n    (I_rst_n),
      .I_set_en   (I_issue_valid),
      .I_set_rd   (I_issue_rd),
      .I_clr_en   (rf_we_q),
      .I_clr_rd   (rf_rd_q),
      .I_rs1      (I_rs1),
      .I_rs2      (I_rs2),
      .O_rs1_pend (rs1_pend),
      .O_rs2_pend (rs2_pend)
   );

   assign O_hazard = rs1_pend || rs2_pend;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//   Directed bench for regfile_wb_scheduler. Expected grant order in the
//   continuous-traffic test follows REGFILE_WB_RR_EN.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

   logic        clk;
   logic        rst_n;
   logic        alu_valid, lsu_valid, issue_valid;
   logic        alu_ready, lsu_ready, hazard;
   logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
   logic [31:0] alu_data, lsu_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   regfile_wb_scheduler #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .I_clk         (clk),
      .I_rst_n       (rst_n),
      .I_alu_valid   (alu_valid),
      .O_alu_ready   (alu_ready),
      .I_alu_rd      (alu_rd),
      .I_alu_data    (alu_data),
      .I_lsu_valid   (lsu_valid),
      .O_lsu_ready   (lsu_ready),
      .I_lsu_rd      (lsu_rd),
      .I_lsu_data    (lsu_data),
      .I_issue_valid (issue_valid),
      .I_issue_rd    (issue_rd),
      .I_rs1         (rs1),
      .I_rs2         (rs2),
      .O_hazard      (hazard),
      .O_rf_we       (rf_we),
      .O_rf_rd       (rf_rd),
      .O_rf_data     (rf_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid   = 1'b0;
      lsu_valid   = 1'b0;
      issue_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
      issue_rd = '0; rs1 = '0; rs2 = '0;

      // Reset state
      #12;
      check("rst_we",     32'(rf_we),   32'd0);
      check("rst_rd",     32'(rf_rd),   32'd0);
      check("rst_data",   rf_data,      32'd0);
      check("rst_hazard", 32'(hazard),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_alu_rdy", 32'(alu_ready), 32'd1);
      check("rst_lsu_rdy", 32'(lsu_ready), 32'd1);

      // ALU only: single write, one-cycle latency from buffer
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      idle();
      check("a_only_rdy",  32'(alu_ready), 32'd1);
      check("a_only_we0",  32'(rf_we),     32'd0);
      tick();
      check("a_only_we",   32'(rf_we),     32'd1);
      check("a_only_rd",   32'(rf_rd),     32'd5);
      check("a_only_data", rf_data,        32'hDEADBEEF);
      tick();
      check("a_only_we_off", 32'(rf_we),   32'd0);
      check("a_only_rd_hold", 32'(rf_rd),  32'd5);

      // Collision: L first, A next cycle
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
      tick();
      idle();
      check("col_alu_rdy0", 32'(alu_ready), 32'd0);
      check("col_lsu_rdy",  32'(lsu_ready), 32'd1);
      tick();
      check("col_we1",    32'(rf_we),     32'd1);
      check("col_rd1",    32'(rf_rd),     32'd4);
      check("col_data1",  rf_data,        32'h22);
      check("col_alu_rdy1", 32'(alu_ready), 32'd1);
      tick();
      check("col_we2",    32'(rf_we),     32'd1);
      check("col_rd2",    32'(rf_rd),     32'd3);
      check("col_data2",  rf_data,        32'h11);
      tick();
      check("col_we_off", 32'(rf_we),     32'd0);

      // Scoreboard set and clear
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      idle();
      rs1 = 5'd7;
      #1;
      check("sb_set", 32'(hazard), 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      tick();
      idle();
      check("sb_buffered", 32'(hazard), 32'd1);
      tick();
      check("sb_we",       32'(rf_we),  32'd1);
      check("sb_at_we",    32'(hazard), 32'd1);
      tick();
      check("sb_cleared",  32'(hazard), 32'd0);

      // Same-cycle issue and commit of rd=9: set wins
      rs1 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      idle();
      tick();
      check("sc_we_rd", 32'(rf_rd), 32'd9);
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      idle();
      rs2 = 5'd9;
      #1;
      check("sc_set_wins", 32'(hazard), 32'd1);

      // rd=0: no write pulse, x0 never pending
      rs2 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      idle();
      check("x0_rdy",   32'(alu_ready), 32'd1);
      check("x0_we_a",  32'(rf_we),     32'd0);
      tick();
      check("x0_we_b",  32'(rf_we),     32'd0);
      check("x0_hazard", 32'(hazard),   32'd0);
      check("x0_rd_hold", 32'(rf_rd),   32'd9);
      check("x0_data_hold", rf_data,    32'h99);

      // Async reset with both buffers full and pending bits 12,13,14 (and 9)
      for (int i = 12; i <= 14; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(i);
         tick();
      end
      idle();
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
      lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD;
      rs1 = 5'd12; rs2 = 5'd13;
      #1;
      check("pre_rst_hazard", 32'(hazard), 32'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we",     32'(rf_we),  32'd0);
      check("arst_rd",     32'(rf_rd),  32'd0);
      check("arst_haz_a",  32'(hazard), 32'd0);
      rs1 = 5'd14; rs2 = 5'd9;
      #1;
      check("arst_haz_b",  32'(hazard), 32'd0);
      check("arst_alu_rdy", 32'(alu_ready), 32'd1);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_we", 32'(rf_we), 32'd0);
      end

      // Continuous traffic from both requesters
      rs1 = 5'd0; rs2 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
      lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'hB0;
      tick();
      for (int i = 0; i < 4; i++) begin
         logic [4:0] exp_rd;
`ifdef REGFILE_WB_RR_EN
         exp_rd = (i % 2 == 0) ? 5'd21 : 5'd20;
`else
         exp_rd = 5'd21;
`endif
         tick();
         check("cont_we", 32'(rf_we), 32'd1);
         check("cont_rd", 32'(rf_rd), 32'(exp_rd));
      end
      idle();
      for (int i = 0; i < 4; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
